// File: rtl/crt_cookie_pkg.sv
// Shared constants and state encoding for the CRT cookie stream checker.
package crt_cookie_pkg;

    localparam logic [7:0] COOKIE_DEF = 8'hB2;
    localparam int         PERIOD_DEF = 4096;
    localparam int         ERR_W      = 8;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/crt_cookie_match.sv
// Serial shift register and cookie comparator. The hit decision includes the
// bit arriving this strobe, so only the previous seven bits need storage.
module crt_cookie_match
    import crt_cookie_pkg::*;
#(
    parameter logic [7:0] COOKIE = COOKIE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ena,
    input  logic i_test,
    output logic o_hit
);

    logic [6:0] r_sr;
    logic [7:0] w_window;

    assign w_window = {r_sr, i_test};
    assign o_hit    = i_ena & (w_window == COOKIE);

    // Shift in one test bit per strobe; the oldest bit falls off the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_sr <= '0;
        else if (i_ena)
            r_sr <= w_window[6:0];
    end

endmodule

// File: rtl/crt_cookie_check.sv
// Cookie stream checker: hunts for the cookie, confirms it recurs at exactly
// PERIOD strobes, then tracks lock with per-period pass/fail pulses and a
// saturating error count.
//
//  state  | meaning
//  SEARCH | hunting for any cookie; phase held at 0
//  VERIFY | cookie seen, counting aligned repeats until CONFIRM reached
//  LOCKED | aligned; each boundary reports ok or err, MISS_LIMIT misses drop
module crt_cookie_check
    import crt_cookie_pkg::*;
#(
    parameter int         PERIOD     = PERIOD_DEF,
    parameter int         CNT_W      = 12,
    parameter logic [7:0] COOKIE     = COOKIE_DEF,
    parameter int         CONFIRM    = 2,
    parameter int         MISS_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             test,
    input  logic             err_clr,
    output logic             locked,
    output logic             cookie_ok,
    output logic             cookie_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] phase
);

    state_t           r_state;
    logic [CNT_W-1:0] r_phase;
    logic [3:0]       r_good;
    logic [3:0]       r_miss;
    logic             r_ok;
    logic             r_err;
    logic [ERR_W-1:0] r_err_cnt;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_phase_nxt;
    logic [3:0]       w_good_nxt;
    logic [3:0]       w_miss_nxt;
    logic             w_ok_nxt;
    logic             w_err_nxt;
    logic [ERR_W-1:0] w_err_cnt_nxt;
    logic [3:0]       w_good_inc;
    logic [3:0]       w_miss_inc;
    logic             w_hit;
    logic             w_boundary;

    crt_cookie_match #(.COOKIE(COOKIE)) u_match (
        .clk    (clk),
        .reset  (reset),
        .i_ena  (ena),
        .i_test (test),
        .o_hit  (w_hit)
    );

    assign w_boundary = ena && (r_phase == CNT_W'(PERIOD - 1));
    assign w_good_inc = r_good + 4'd1;
    assign w_miss_inc = r_miss + 4'd1;

    // State register plus all registered outputs and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= SEARCH;
            r_phase   <= '0;
            r_good    <= '0;
            r_miss    <= '0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_good    <= w_good_nxt;
            r_miss    <= w_miss_nxt;
            r_ok      <= w_ok_nxt;
            r_err     <= w_err_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    // Next-state, phase/confirm/miss bookkeeping and pulse decisions.
    // PERIOD is a power of two, so phase+1 at the boundary wraps to 0 by itself.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss;
        w_ok_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            SEARCH: begin
                w_phase_nxt = '0;
                if (w_hit) begin
                    w_good_nxt  = 4'd1;
                    w_state_nxt = VERIFY;
                end
            end
            VERIFY: begin
                if (ena) begin
                    w_phase_nxt = r_phase + CNT_W'(1);
                    if (w_boundary) begin
                        if (w_hit) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc == 4'(CONFIRM)) begin
                                w_state_nxt = LOCKED;
                                w_miss_nxt  = '0;
                            end
                        end else begin
                            // the failing strobe is not reused as a new start
                            w_state_nxt = SEARCH;
                            w_good_nxt  = '0;
                        end
                    end
                end
            end
            LOCKED: begin
                if (ena) begin
                    w_phase_nxt = r_phase + CNT_W'(1);
                    if (w_boundary) begin
                        if (w_hit) begin
                            w_ok_nxt   = 1'b1;
                            w_miss_nxt = '0;
                        end else begin
                            w_err_nxt  = 1'b1;
                            w_miss_nxt = w_miss_inc;
                            if (w_miss_inc == 4'(MISS_LIMIT)) begin
                                w_state_nxt = SEARCH;
                                w_miss_nxt  = '0;
                                w_good_nxt  = '0;
                            end
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = SEARCH;
                w_phase_nxt = '0;
                w_good_nxt  = '0;
                w_miss_nxt  = '0;
            end
        endcase
    end

    // Error counter: clear has priority over a same-cycle increment; saturates.
    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        if (err_clr)
            w_err_cnt_nxt = '0;
        else if (w_err_nxt && (r_err_cnt != '1))
            w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
    end

    assign locked     = (r_state == LOCKED);
    assign cookie_ok  = r_ok;
    assign cookie_err = r_err;
    assign err_cnt    = r_err_cnt;
    assign phase      = r_phase;

endmodule

// File: tb/tb_crt_cookie_check.sv
// Scoreboard bench for crt_cookie_check, run with a short 32-strobe period.
// The stream generator pushes the expected pulse for each period boundary;
// a monitor pops and compares whenever cookie_ok or cookie_err appears.
module tb_crt_cookie_check;

    localparam int P     = 32;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          ena;
    logic          test;
    logic          err_clr;
    logic          locked;
    logic          cookie_ok;
    logic          cookie_err;
    logic [7:0]    err_cnt;
    logic [CW-1:0] phase;

    typedef struct {
        bit is_err;
        int err;
        bit lk;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         thr   = 1;
    int         e     = 0;
    logic [6:0] hist  = '0;
    logic [15:0] lfsr = 16'hACE1;
    logic [7:0] cv    = 8'hB2;

    crt_cookie_check #(.PERIOD(P), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .test       (test),
        .err_clr    (err_clr),
        .locked     (locked),
        .cookie_ok  (cookie_ok),
        .cookie_err (cookie_err),
        .err_cnt    (err_cnt),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (cookie_ok || cookie_err)) begin
            chk("pulse_exclusive", int'(cookie_ok && cookie_err), 0);
            if (q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("pulse_kind", int'(cookie_err), int'(x.is_err));
                chk("pulse_err_cnt", int'(err_cnt), x.err);
                chk("pulse_locked", int'(locked), int'(x.lk));
            end
        end
    end

    task automatic send_bit(input logic b);
        for (int k = 0; k < thr - 1; k++) begin
            ena  = 1'b0;
            test = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        ena  = 1'b1;
        test = b;
        hist = {hist[5:0], b};
        @(negedge clk);
        ena  = 1'b0;
    endtask

    // Noise with accidental cookies suppressed; force_one guards the single
    // overlap case (cookie prefix "10" equals its suffix) before a real cookie.
    task automatic send_noise(input bit force_one);
        logic b;
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        b = lfsr[0];
        if (force_one)
            b = 1'b1;
        else if ({hist, b} == cv)
            b = ~b;
        send_bit(b);
    endtask

    // One period of P strobes; a cookie, if present, ends on the last strobe.
    // kind: 0 no pulse expected, 1 cookie_ok, 2 cookie_err.
    task automatic send_period(input bit with_cookie, input int alias_end, input int kind,
                               input int exp_err, input bit exp_lk, input int mid_exp,
                               input bit clr_end);
        for (int p = 0; p < P; p++) begin
            if (p == P - 1 && kind != 0) begin
                exp_t x;
                x.is_err = (kind == 2);
                x.err    = exp_err;
                x.lk     = exp_lk;
                q.push_back(x);
            end
            if (clr_end && p == P - 1) err_clr = 1'b1;
            if (with_cookie && p >= P - 8)
                send_bit(cv[P - 1 - p]);
            else if (alias_end >= 0 && p <= alias_end && p >= alias_end - 7)
                send_bit(cv[alias_end - p]);
            else
                send_noise((with_cookie && p == P - 9) || (alias_end >= 0 && p == alias_end - 8));
            err_clr = 1'b0;
            if (alias_end >= 0 && p == alias_end)
                chk("alias_phase", int'(phase), alias_end + 1);
            if (p == P / 2 - 1 && mid_exp >= 0)
                chk("mid_phase", int'(phase), mid_exp);
        end
    endtask

    task automatic per(input bit c, input int kind, input bit lk, input int mid);
        if (kind == 2) e = (e >= 255) ? 255 : e + 1;
        send_period(c, -1, kind, e, lk, mid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; ena = 1'b0; test = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_locked", int'(locked), 0);
        chk("rst_ok", int'(cookie_ok), 0);
        chk("rst_err", int'(cookie_err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_phase", int'(phase), 0);
        reset = 1'b0;
        @(negedge clk);

        // clean stream: SEARCH -> VERIFY -> LOCKED -> ok pulses
        for (int i = 0; i < 20; i++) send_noise(1'b0);
        per(1, 0, 0, 0);
        chk("verify_locked", int'(locked), 0);
        chk("verify_phase", int'(phase), 0);
        per(1, 0, 1, P / 2);
        chk("lock_after_confirm", int'(locked), 1);
        per(1, 1, 1, P / 2);
        per(1, 1, 1, P / 2);
        chk("clean_err_cnt", int'(err_cnt), 0);

        // alias mid-period while locked: ignored
        send_period(1'b1, 10, 1, e, 1'b1, P / 2, 1'b0);
        chk("alias_locked", int'(locked), 1);

        // single drop, recovery, then three drops lose lock
        per(0, 2, 1, P / 2);
        per(1, 1, 1, P / 2);
        per(0, 2, 1, P / 2);
        per(0, 2, 1, P / 2);
        per(0, 2, 0, P / 2);
        chk("drop3_locked", int'(locked), 0);
        chk("drop3_err_cnt", int'(err_cnt), 4);

        // false start: one cookie, none a period later
        per(1, 0, 0, 0);
        per(0, 0, 0, P / 2);
        per(0, 0, 0, 0);
        chk("false_start_locked", int'(locked), 0);

        // throttled ena: same behaviour in strobe terms
        thr = 3;
        per(1, 0, 0, 0);
        per(1, 0, 1, P / 2);
        per(1, 1, 1, P / 2);
        per(1, 1, 1, P / 2);
        chk("thr_locked", int'(locked), 1);
        thr = 1;

        // drive err_cnt into saturation
        for (int g = 0; g < 85; g++) begin
            per(0, 2, 1, P / 2);
            per(0, 2, 1, P / 2);
            per(0, 2, 0, P / 2);
            per(1, 0, 0, 0);
            per(1, 0, 1, P / 2);
        end
        chk("sat_err_cnt", int'(err_cnt), 255);
        chk("sat_locked", int'(locked), 1);

        // err_clr on a cookie_err cycle wins over the increment
        e = 0;
        send_period(1'b0, -1, 2, 0, 1'b1, P / 2, 1'b1);
        per(0, 2, 1, P / 2);
        per(1, 1, 1, P / 2);
        chk("clr_locked", int'(locked), 1);

        // reset while locked at phase 20
        for (int p = 0; p < 20; p++) send_noise(1'b0);
        chk("pre_reset_phase", int'(phase), 20);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_ok", int'(cookie_ok), 0);
        chk("midrst_err", int'(cookie_err), 0);
        chk("midrst_err_cnt", int'(err_cnt), 0);
        chk("midrst_phase", int'(phase), 0);
        reset = 1'b0;
        e = 0;
        @(negedge clk);
        per(1, 0, 0, 0);
        chk("relock_first", int'(locked), 0);
        per(1, 0, 1, P / 2);
        chk("relock_second", int'(locked), 1);
        per(1, 1, 1, P / 2);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
